uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx_if.sv | 29 ++
 rtl/uart_rx.sv | 142 ++++++++++++++
 tb/tb_uart_rx.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Bundle of the UART receiver's line-side inputs and its byte-side outputs.
//
// Handshake: rx_done is a one-cycle valid strobe with no ready. In the cycle
// it is high, d_out and frame_err already carry the new frame's values. The
// consumer must capture them in that cycle. Both outputs then hold until the
// next strobe.
interface uart_rx_if;
    logic       s_tick;
    logic       rx;
    logic [7:0] d_out;
    logic       rx_done;
    logic       frame_err;

    modport master (
        output s_tick,
        output rx,
        input  d_out,
        input  rx_done,
        input  frame_err
    );

    modport slave (
        input  s_tick,
        input  rx,
        output d_out,
        output rx_done,
        output frame_err
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver with 16x oversampling.
// Frame format: 1 start bit, DBIT data bits sent LSB first, then 1 stop bit.
// The start bit is qualified at its midpoint. After that, every data bit and
// the stop bit are sampled 16 ticks apart.
module uart_rx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic       clk,
    input  logic       reset,
    uart_rx_if.slave   bus,
    output logic [1:0] state_dbg
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // Received bits enter at the MSB of b, so the byte ends up in the top
    // DBIT bits. Shifting right by this amount right-aligns it.
    localparam int     ALIGN     = 8 - DBIT;
    localparam logic [2:0] LAST_BIT  = 3'(DBIT - 1);
    localparam logic [3:0] STOP_LAST = 4'(SB_TICK - 1);

    state_t     state, state_n;
    logic [3:0] s, s_n;
    logic [2:0] n, n_n;
    logic [7:0] b, b_n;
    logic [7:0] d_out_r, d_out_n;
    logic       ferr_r, ferr_n;
    logic       done_r, done_n;
    logic       rx_meta, rx_s, rx_prev;

    // Two-flop synchronizer plus one more stage for falling-edge detection.
    // All three stages reset to the idle line level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= bus.rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    // State, counters, shift register and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            s       <= '0;
            n       <= '0;
            b       <= '0;
            d_out_r <= '0;
            ferr_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state   <= state_n;
            s       <= s_n;
            n       <= n_n;
            b       <= b_n;
            d_out_r <= d_out_n;
            ferr_r  <= ferr_n;
            done_r  <= done_n;
        end
    end

    // Next-state logic. Outside IDLE, nothing advances without s_tick.
    // The stop-bit sample loads d_out and frame_err together with the
    // one-cycle done strobe.
    always_comb begin
        state_n = state;
        s_n     = s;
        n_n     = n;
        b_n     = b;
        d_out_n = d_out_r;
        ferr_n  = ferr_r;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                // Edge detection here does not wait for a tick.
                if (rx_prev && !rx_s) begin
                    state_n = START;
                    s_n     = '0;
                end
            end
            START: begin
                if (bus.s_tick) begin
                    if (s == 4'd7) begin
                        if (!rx_s) begin
                            state_n = DATA;
                            s_n     = '0;
                            n_n     = '0;
                        end else begin
                            // The line is high again at mid start bit, so the
                            // low pulse was a glitch.
                            state_n = IDLE;
                        end
                    end else begin
                        s_n = s + 4'd1;
                    end
                end
            end
            DATA: begin
                if (bus.s_tick) begin
                    if (s == 4'd15) begin
                        s_n = '0;
                        b_n = {rx_s, b[7:1]};
                        if (n == LAST_BIT) begin
                            state_n = STOP;
                        end else begin
                            n_n = n + 3'd1;
                        end
                    end else begin
                        s_n = s + 4'd1;
                    end
                end
            end
            STOP: begin
                if (bus.s_tick) begin
                    if (s == STOP_LAST) begin
                        d_out_n = b >> ALIGN;
                        ferr_n  = ~rx_s;
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        s_n = s + 4'd1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.d_out     = d_out_r;
    assign bus.frame_err = ferr_r;
    assign bus.rx_done   = done_r;
    assign state_dbg     = state;
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx.
// The bench generates s_tick every 4 clocks, so one bit lasts 64 clocks.
// One 8-bit receiver and one 7-bit receiver each get their own rx line.
module tb_uart_rx;
    logic clk;
    logic reset;
    logic [1:0] state8, state7;
    logic [1:0] tick_div;
    int total = 0;
    int bad = 0;
    int done8 = 0;
    int done7 = 0;
    int dbl = 0;
    logic prev8 = 1'b0;
    logic prev7 = 1'b0;
    logic [8:0] got8_q[$];
    logic [8:0] got7_q[$];
    int done_before;

    uart_rx_if bus8();
    uart_rx_if bus7();

    uart_rx #(.DBIT(8), .SB_TICK(16)) dut8 (
        .clk(clk), .reset(reset), .bus(bus8.slave), .state_dbg(state8)
    );
    uart_rx #(.DBIT(7), .SB_TICK(16)) dut7 (
        .clk(clk), .reset(reset), .bus(bus7.slave), .state_dbg(state7)
    );

    // Clock: 10-time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Oversample tick: one clock in every four, driven away from posedge.
    initial begin
        tick_div     = 2'd0;
        bus8.s_tick  = 1'b0;
        bus7.s_tick  = 1'b0;
        forever begin
            @(negedge clk);
            tick_div    = tick_div + 2'd1;
            bus8.s_tick = (tick_div == 2'd3);
            bus7.s_tick = (tick_div == 2'd3);
        end
    end

    // Monitor: capture every done strobe and catch any strobe longer than one cycle.
    always @(negedge clk) begin
        if (bus8.rx_done) begin
            got8_q.push_back({bus8.frame_err, bus8.d_out});
            done8++;
        end
        if (bus7.rx_done) begin
            got7_q.push_back({bus7.frame_err, bus7.d_out});
            done7++;
        end
        if ((bus8.rx_done && prev8) || (bus7.rx_done && prev7)) dbl++;
        prev8 = bus8.rx_done;
        prev7 = bus7.rx_done;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_line(input bit sel, input logic v);
        if (sel) bus7.rx = v;
        else bus8.rx = v;
    endtask

    task automatic drive_bit(input bit sel, input logic v);
        @(negedge clk);
        set_line(sel, v);
        repeat (63) @(negedge clk);
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] data, input int nbits, input logic stop);
        drive_bit(sel, 1'b0);
        for (int i = 0; i < nbits; i++) drive_bit(sel, data[i]);
        drive_bit(sel, stop);
    endtask

    task automatic idle_bits(input bit sel, input int nb);
        for (int i = 0; i < nb; i++) drive_bit(sel, 1'b1);
    endtask

    // Wait a bounded time for a captured frame, then compare it against the expected values.
    task automatic expect_frame(input string tag, input bit sel, input logic [7:0] exp_d, input logic exp_fe);
        logic [8:0] got;
        int waited;
        int sz;
        waited = 0;
        sz = sel ? got7_q.size() : got8_q.size();
        while (sz == 0 && waited < 1500) begin
            @(negedge clk);
            waited++;
            sz = sel ? got7_q.size() : got8_q.size();
        end
        check({tag, "_seen"}, (sz > 0) ? 32'd1 : 32'd0, 32'd1);
        if (sz > 0) begin
            got = sel ? got7_q.pop_front() : got8_q.pop_front();
            check({tag, "_d_out"}, {24'd0, got[7:0]}, {24'd0, exp_d});
            check({tag, "_frame_err"}, {31'd0, got[8]}, {31'd0, exp_fe});
        end
    endtask

    initial begin
        reset   = 1'b1;
        bus8.rx = 1'b1;
        bus7.rx = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // Reset state
        check("rst_d_out", {24'd0, bus8.d_out}, 32'h00);
        check("rst_rx_done", {31'd0, bus8.rx_done}, 32'd0);
        check("rst_frame_err", {31'd0, bus8.frame_err}, 32'd0);
        check("rst_state", {30'd0, state8}, 32'd0);

        // Basic frame
        send_frame(1'b0, 8'hA5, 8, 1'b1);
        expect_frame("a5", 1'b0, 8'hA5, 1'b0);
        idle_bits(1'b0, 1);

        // Glitch of 5 ticks (20 clocks) must be rejected at mid start bit
        done_before = done8;
        @(negedge clk);
        bus8.rx = 1'b0;
        repeat (20) @(negedge clk);
        bus8.rx = 1'b1;
        repeat (200) @(negedge clk);
        check("glitch_state_idle", {30'd0, state8}, 32'd0);
        check("glitch_no_done", done8, done_before);
        send_frame(1'b0, 8'h3C, 8, 1'b1);
        expect_frame("3c", 1'b0, 8'h3C, 1'b0);
        idle_bits(1'b0, 1);

        // Reset in the middle of data bit 4 of 0xFF
        done_before = done8;
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b0, 1'b1);
        repeat (32) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_d_out", {24'd0, bus8.d_out}, 32'h00);
        check("midrst_frame_err", {31'd0, bus8.frame_err}, 32'd0);
        check("midrst_state", {30'd0, state8}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (400) @(negedge clk);
        check("midrst_no_done", done8, done_before);
        send_frame(1'b0, 8'h5A, 8, 1'b1);
        expect_frame("5a", 1'b0, 8'h5A, 1'b0);
        idle_bits(1'b0, 1);

        // Stop bit forced low sets frame_err; a later good frame clears it
        send_frame(1'b0, 8'h81, 8, 1'b0);
        expect_frame("81_bad_stop", 1'b0, 8'h81, 1'b1);
        idle_bits(1'b0, 2);
        check("81_d_out_held", {24'd0, bus8.d_out}, 32'h81);
        check("81_frame_err_held", {31'd0, bus8.frame_err}, 32'd1);
        send_frame(1'b0, 8'h00, 8, 1'b1);
        expect_frame("00", 1'b0, 8'h00, 1'b0);
        idle_bits(1'b0, 1);

        // Back-to-back frames with zero idle gap
        send_frame(1'b0, 8'h55, 8, 1'b1);
        send_frame(1'b0, 8'hAA, 8, 1'b1);
        expect_frame("b2b_55", 1'b0, 8'h55, 1'b0);
        expect_frame("b2b_aa", 1'b0, 8'hAA, 1'b0);
        idle_bits(1'b0, 1);

        // 7-bit receiver
        send_frame(1'b1, 8'h7F, 7, 1'b1);
        expect_frame("dbit7_7f", 1'b1, 8'h7F, 1'b0);
        idle_bits(1'b1, 1);
        send_frame(1'b1, 8'h2A, 7, 1'b1);
        expect_frame("dbit7_2a", 1'b1, 8'h2A, 1'b0);
        idle_bits(1'b1, 1);

        // Pulse totals and pulse width
        check("done8_total", done8, 32'd7);
        check("done7_total", done7, 32'd2);
        check("no_double_pulse", dbl, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
